// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg
//   Shared types and defaults for the ADC capture sequencer.
//   - state_e      : burst-control FSM state encoding
//   - DEF_DATA_W   : default ADC sample width
//   - DEF_CNT_W    : default sample-count width
//   - DEF_MIN_DIV  : default smallest accepted divider ratio
package adc_seq_pkg;

    localparam int unsigned DEF_DATA_W  = 12;
    localparam int unsigned DEF_CNT_W   = 16;
    localparam int unsigned DEF_MIN_DIV = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

endpackage

// File: rtl/adc_capture_sequencer_edge_detect.sv
// edge_detect
//   Registers a signal that already lives in the clk_i domain and flags its
//   rising edge for one cycle.
//   Ports:
//     clk_i  : system clock
//     rst_i  : synchronous active-high reset (clears the history register)
//     sig_i  : monitored signal (divided clock)
//     rise_o : high in the cycle where sig_i is 1 and was 0 one clock earlier
module edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer
//   Runs one ADC capture burst: programs and enables the sample-clock divider,
//   captures the ADC word on every rising edge of the divided clock, offers it
//   on a one-entry valid/ready output and stops after n_samples captures.
//   Ports:
//     clk_in, reset             : system clock, synchronous active-high reset
//     start, abort              : burst request / termination
//     divisor_cfg, n_samples    : burst configuration, latched on start
//     div_switch, div_divisor   : divider enable and ratio
//     div_clk                   : divided clock (registered in clk_in domain)
//     adc_data                  : ADC parallel word
//     sample_data/valid/ready   : captured-sample handshake
//     busy, done                : status; done pulses once per completed burst
//     overrun                   : sticky, a sample was replaced before read
//     cfg_err                   : pulses when a start is rejected
module adc_capture_sequencer
    import adc_seq_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned MIN_DIV = DEF_MIN_DIV
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       divisor_cfg,
    input  logic [CNT_W-1:0]  n_samples,
    output logic              div_switch,
    output logic [31:0]       div_divisor,
    input  logic              div_clk,
    input  logic [DATA_W-1:0] adc_data,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic              cfg_err
);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [CNT_W-1:0]    n_q;
    logic                div_switch_q;
    logic [31:0]         div_divisor_q;
    logic [DATA_W-1:0]   data_q;
    logic                valid_q;
    logic                done_q;
    logic                overrun_q;
    logic                cfg_err_q;
    logic                div_rise;
    logic                cfg_ok;
    logic                handshake;

    edge_detect u_edge (
        .clk_i  (clk_in),
        .rst_i  (reset),
        .sig_i  (div_clk),
        .rise_o (div_rise)
    );

    assign cnt_d     = cnt_q + CNT_W'(1);
    assign cfg_ok    = (divisor_cfg >= MIN_DIV) && (n_samples != '0);
    assign handshake = valid_q & sample_ready;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            n_q           <= '0;
            div_switch_q  <= 1'b0;
            div_divisor_q <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            // Consumption is independent of state; a capture below overrides it.
            if (handshake) begin
                valid_q <= 1'b0;
            end
            if (abort && (state_q != S_IDLE)) begin
                state_q      <= S_IDLE;
                div_switch_q <= 1'b0;
                valid_q      <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            if (cfg_ok) begin
                                n_q           <= n_samples;
                                div_divisor_q <= divisor_cfg;
                                overrun_q     <= 1'b0;
                                cnt_q         <= '0;
                                state_q       <= S_ARM;
                            end else begin
                                cfg_err_q <= 1'b1;
                            end
                        end
                    end
                    // One cycle with the new ratio on div_divisor before enabling.
                    S_ARM: begin
                        div_switch_q <= 1'b1;
                        state_q      <= S_RUN;
                    end
                    S_RUN: begin
                        if (div_rise) begin
                            data_q  <= adc_data;
                            valid_q <= 1'b1;
                            cnt_q   <= cnt_d;
                            if (valid_q && !sample_ready) begin
                                overrun_q <= 1'b1;
                            end
                            if (cnt_d == n_q) begin
                                div_switch_q <= 1'b0;
                                state_q      <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (!valid_q || sample_ready) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign div_switch   = div_switch_q;
    assign div_divisor  = div_divisor_q;
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign overrun      = overrun_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// tb_adc_capture_sequencer
//   Directed bench for adc_capture_sequencer. Stimulus pushes the expected
//   captured word into a queue when it produces a divided-clock edge; a
//   monitor pops and compares on every accepted output beat.
module tb_adc_capture_sequencer;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned CNT_W  = 16;

    logic              clk_in = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [31:0]       divisor_cfg;
    logic [CNT_W-1:0]  n_samples;
    logic              div_switch;
    logic [31:0]       div_divisor;
    logic              div_clk;
    logic [DATA_W-1:0] adc_data;
    logic [DATA_W-1:0] sample_data;
    logic              sample_valid;
    logic              sample_ready;
    logic              busy;
    logic              done;
    logic              overrun;
    logic              cfg_err;

    int n_vec = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] saved;

    adc_capture_sequencer #(
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W),
        .MIN_DIV (2)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .divisor_cfg  (divisor_cfg),
        .n_samples    (n_samples),
        .div_switch   (div_switch),
        .div_divisor  (div_divisor),
        .div_clk      (div_clk),
        .adc_data     (adc_data),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun),
        .cfg_err      (cfg_err)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every accepted beat must match the oldest expectation.
    always @(negedge clk_in) begin
        if (!reset && sample_valid && sample_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sample_beat: unexpected beat data=%0h, none expected", sample_data);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                if (sample_data !== e) begin
                    n_err++;
                    $display("FAIL sample_beat: got %0h expected %0h", sample_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; adc_data ramps each cycle.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
            adc_data = adc_data + 1'b1;
        end
    endtask

    // One-cycle-high divided clock pulse; optionally records the word it captures.
    task automatic edge_pulse(input bit push);
        div_clk = 1'b1;
        if (push) exp_q.push_back(adc_data);
        tick();
        div_clk = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_div_switch"},   {31'd0, div_switch},   32'd0);
        chk({tag, "_div_divisor"},  div_divisor,           32'd0);
        chk({tag, "_sample_valid"}, {31'd0, sample_valid}, 32'd0);
        chk({tag, "_sample_data"},  {20'd0, sample_data},  32'd0);
        chk({tag, "_busy"},         {31'd0, busy},         32'd0);
        chk({tag, "_done"},         {31'd0, done},         32'd0);
        chk({tag, "_overrun"},      {31'd0, overrun},      32'd0);
        chk({tag, "_cfg_err"},      {31'd0, cfg_err},      32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        divisor_cfg  = 32'd0;
        n_samples    = '0;
        div_clk      = 1'b0;
        adc_data     = 12'h100;
        sample_ready = 1'b0;
        tick(2);
        reset = 1'b0;
        chk_reset_values("rst");

        // Basic burst: divisor 4, three samples, ready held high.
        sample_ready = 1'b1;
        divisor_cfg  = 32'd4;
        n_samples    = 16'd3;
        start        = 1'b1;
        tick();
        start = 1'b0;
        chk("b_arm_busy",       {31'd0, busy},       32'd1);
        chk("b_arm_switch",     {31'd0, div_switch}, 32'd0);
        chk("b_arm_divisor",    div_divisor,         32'd4);
        tick();
        chk("b_run_switch",     {31'd0, div_switch}, 32'd1);
        edge_pulse(1'b1);
        chk("b_e1_switch",      {31'd0, div_switch}, 32'd1);
        chk("b_e1_valid",       {31'd0, sample_valid}, 32'd1);
        tick(3);
        edge_pulse(1'b1);
        tick(3);
        edge_pulse(1'b1);
        chk("b_e3_switch_off",  {31'd0, div_switch}, 32'd0);
        chk("b_e3_done_low",    {31'd0, done},       32'd0);
        tick();
        chk("b_done_pulse",     {31'd0, done},       32'd1);
        chk("b_overrun",        {31'd0, overrun},    32'd0);
        chk("b_done_busy",      {31'd0, busy},       32'd1);
        tick();
        chk("b_idle_done",      {31'd0, done},       32'd0);
        chk("b_idle_busy",      {31'd0, busy},       32'd0);

        // Backpressure: divisor 2, four samples, ready low; only sample 4 survives.
        sample_ready = 1'b0;
        divisor_cfg  = 32'd2;
        n_samples    = 16'd4;
        start        = 1'b1;
        tick();
        start = 1'b0;
        tick();
        edge_pulse(1'b0);
        chk("bp_e1_overrun",    {31'd0, overrun},    32'd0);
        tick();
        edge_pulse(1'b0);
        chk("bp_e2_overrun",    {31'd0, overrun},    32'd1);
        tick();
        edge_pulse(1'b0);
        tick();
        edge_pulse(1'b1);
        chk("bp_drain_switch",  {31'd0, div_switch}, 32'd0);
        chk("bp_drain_valid",   {31'd0, sample_valid}, 32'd1);
        tick();
        edge_pulse(1'b0);       // edge while draining must not replace the sample
        tick(2);
        chk("bp_drain_busy",    {31'd0, busy},       32'd1);
        chk("bp_drain_done",    {31'd0, done},       32'd0);
        sample_ready = 1'b1;
        tick();
        chk("bp_done_pulse",    {31'd0, done},       32'd1);
        chk("bp_overrun_kept",  {31'd0, overrun},    32'd1);
        tick();
        chk("bp_idle_busy",     {31'd0, busy},       32'd0);

        // Config reject: divisor below minimum, then zero sample count.
        divisor_cfg = 32'd1;
        n_samples   = 16'd5;
        start       = 1'b1;
        tick();
        start = 1'b0;
        chk("rej1_cfg_err",     {31'd0, cfg_err},    32'd1);
        chk("rej1_busy",        {31'd0, busy},       32'd0);
        chk("rej1_switch",      {31'd0, div_switch}, 32'd0);
        chk("rej1_divisor",     div_divisor,         32'd2);
        chk("rej1_overrun",     {31'd0, overrun},    32'd1);
        tick();
        chk("rej1_pulse_end",   {31'd0, cfg_err},    32'd0);
        divisor_cfg = 32'd6;
        n_samples   = 16'd0;
        start       = 1'b1;
        tick();
        start = 1'b0;
        chk("rej2_cfg_err",     {31'd0, cfg_err},    32'd1);
        chk("rej2_divisor",     div_divisor,         32'd2);
        tick();

        // Abort mid-RUN after two samples; abort coincides with a third edge.
        divisor_cfg = 32'd8;
        n_samples   = 16'd10;
        start       = 1'b1;
        tick();
        start = 1'b0;
        chk("ab_overrun_clr",   {31'd0, overrun},    32'd0);
        chk("ab_divisor",       div_divisor,         32'd8);
        tick();
        edge_pulse(1'b1);
        tick(7);
        edge_pulse(1'b1);
        tick(6);
        div_clk = 1'b1;
        abort   = 1'b1;
        tick();
        div_clk = 1'b0;
        abort   = 1'b0;
        chk("ab_switch",        {31'd0, div_switch}, 32'd0);
        chk("ab_valid",         {31'd0, sample_valid}, 32'd0);
        chk("ab_busy",          {31'd0, busy},       32'd0);
        chk("ab_no_done",       {31'd0, done},       32'd0);
        tick();
        chk("ab_no_done2",      {31'd0, done},       32'd0);
        divisor_cfg = 32'd2;
        n_samples   = 16'd1;
        start       = 1'b1;
        tick();
        start = 1'b0;
        chk("ab_restart_busy",  {31'd0, busy},       32'd1);
        tick();
        edge_pulse(1'b1);
        chk("ab_restart_off",   {31'd0, div_switch}, 32'd0);
        tick();
        chk("ab_restart_done",  {31'd0, done},       32'd1);
        tick();

        // Coincidence, start ignored during RUN, reset during DRAIN.
        divisor_cfg = 32'd2;
        n_samples   = 16'd3;
        start       = 1'b1;
        tick();
        start = 1'b0;
        tick();
        sample_ready = 1'b0;
        divisor_cfg  = 32'd9;
        n_samples    = 16'd1;
        start        = 1'b1;
        edge_pulse(1'b1);
        start = 1'b0;
        chk("co_start_ign_div", div_divisor,         32'd2);
        chk("co_start_ign_bsy", {31'd0, busy},       32'd1);
        tick();
        sample_ready = 1'b1;
        edge_pulse(1'b1);       // edge and valid&ready in the same cycle
        chk("co_no_overrun",    {31'd0, overrun},    32'd0);
        chk("co_valid_new",     {31'd0, sample_valid}, 32'd1);
        chk("co_still_run",     {31'd0, div_switch}, 32'd1);
        tick();
        sample_ready = 1'b0;
        saved = adc_data;
        edge_pulse(1'b0);
        chk("co_drain_switch",  {31'd0, div_switch}, 32'd0);
        chk("co_drain_data",    {20'd0, sample_data}, {20'd0, saved});
        chk("co_drain_ovr",     {31'd0, overrun},    32'd0);
        tick();
        chk("co_drain_busy",    {31'd0, busy},       32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_values("mid");
        tick();
        chk("mid_no_done",      {31'd0, done},       32'd0);

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adc_capture_sequencer.md
# adc_capture_sequencer

Controls one ADC capture burst. It programs and gates the sample-clock divider (drives its divisor and enable), and detects rising edges of the divided clock in the system clock domain. On each edge it captures the ADC parallel word and presents it on a one-entry valid/ready output. It stops the divider after a programmed number of samples. It sits between the localization control logic (start/abort/config) and the divider plus ADC pins.

## Interface
Parameters:
- DATA_W, 12, ADC sample width
- CNT_W, 16, sample-count width
- MIN_DIV, 2, smallest accepted divisor

Ports:
- clk_in  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a burst
- abort  in  1  terminate the burst in progress
- divisor_cfg  in  32  divider ratio for the burst
- n_samples  in  CNT_W  samples per burst
- div_switch  out  1  divider enable
- div_divisor  out  32  divider ratio, held stable for the whole burst
- div_clk  in  1  divided clock, generated by registered logic in the clk_in domain (no synchronizer needed)
- adc_data  in  DATA_W  ADC parallel output
- sample_data  out  DATA_W  captured sample
- sample_valid  out  1  sample_data is valid
- sample_ready  in  1  downstream accepts the sample
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at burst completion
- overrun  out  1  sticky flag: a sample was dropped
- cfg_err  out  1  one-cycle pulse: start was rejected

## Operation
- States: IDLE, ARM, RUN, DRAIN, DONE.
- IDLE, start=1:
  - Config valid (divisor_cfg>=MIN_DIV and n_samples!=0): latch n_samples, load div_divisor, clear overrun, clear the sample counter, go to ARM.
  - Config invalid: pulse cfg_err, stay in IDLE, change nothing else.
- ARM: exactly one cycle, so div_divisor settles before enable. Set div_switch=1, go to RUN.
- RUN: edge = div_clk & ~div_clk_q, where div_clk_q is div_clk registered in clk_in. On an edge:
  - Capture adc_data from that same cycle into the output register.
  - Increment the counter.
  - Drop rule: if sample_valid=1 and sample_ready=0 in that cycle, discard the old sample, keep the new one, and set overrun.
  - If valid&ready and an edge occur in the same cycle, the new sample loads and there is no overrun.
- RUN exit: when the counter reaches the latched n (on the counting edge), clear div_switch on the next clock and go to DRAIN.
- DRAIN: hold until the output register is empty (sample_valid=0, or valid&ready this cycle). Then go to DONE. Edges in DRAIN are ignored.
- DONE: done=1 for one cycle, then go to IDLE.
- start outside IDLE is ignored.
- Changes to divisor_cfg or n_samples after the latch have no effect.
- abort in ARM, RUN, DRAIN or DONE:
  - Next cycle: div_switch=0, sample_valid=0, state IDLE.
  - No done pulse; overrun is kept.
  - abort has priority over every other event in that cycle.
- The counter is CNT_W bits and never wraps, because the burst ends at n, with n ≤ 2^CNT_W−1.

## Timing
- Values after reset:
  - state IDLE
  - div_switch=0, div_divisor=0
  - sample_valid=0, sample_data=0
  - busy=0, done=0, overrun=0, cfg_err=0
  - div_clk_q=0
- start sampled at cycle t: ARM at t+1, div_switch=1 from t+2.
- Edge detected at cycle t: sample_valid=1 at t+1, sample_data = adc_data(t).
- Last edge at cycle t: div_switch=0 at t+1. Earliest done is t+2, when the sample is consumed at t+1.
- busy goes high the cycle after an accepted start and low the cycle after done.
- reset asserted mid-burst returns to the reset values on the next clock; no done is generated.

## Structure
- Package adc_seq_pkg holds:
  - the state enum type
  - the default MIN_DIV constant
  - the DATA_W/CNT_W defaults
- One sub-module, edge_detect: registers div_clk and outputs a one-cycle rise pulse.
- The FSM, counter and output register stay in the top module.

## Test plan
- Basic burst: divisor_cfg=4, n_samples=3, sample_ready=1, adc_data ramps by 1 each cycle. Expect 3 valid beats, each with the adc_data value from its edge cycle; div_switch high for the burst and low after edge 3; one done pulse; overrun=0.
- Backpressure: divisor_cfg=2, n_samples=4, sample_ready=0 throughout. Expect overrun=1 after the 2nd edge; only the 4th sample is presented; the block stays in DRAIN until ready=1 is applied, then done.
- Config reject: start with divisor_cfg=1 or n_samples=0. Expect a cfg_err pulse, busy=0, div_switch=0, div_divisor unchanged.
- Abort mid-RUN: divisor_cfg=8, n_samples=10, abort after 2 samples. Expect div_switch=0 and sample_valid=0 the next cycle, no done, and a new start accepted afterwards.
- Coincidence and ignore: an edge and valid&ready in the same cycle gives no overrun; start asserted during RUN changes nothing; reset during DRAIN restores all reset values.
